joe_motion: RTL
===============

# joe_motion

Sequential position generator for the Joe sprite. Once per video frame it updates the sprite centre from the keyboard keycode, keeping the 85×93 bounding box fully on the 640×480 screen. It runs a ground/rise/fall jump state machine. Its `centerx`/`centery` outputs drive the pixel-in-sprite comparator that the color mapper samples for every pixel.

## Interface
Parameters:
- `X_START`, 320: reset horizontal centre.
- `Y_GROUND`, 433: ground-level centre; equals 479 − `HALF_H`.
- `HALF_W`, 42: horizontal half-extent of the bounding box.
- `HALF_H`, 46: vertical half-extent of the bounding box.
- `STEP`, 2: horizontal pixels moved per frame.
- `JUMP_V0`, 12: initial upward velocity, in pixels per frame.
- `V_MAX`, 15: fall-velocity cap.

Ports:
- `Clk`, in, 1: system clock; all state is on its rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `frame_clk`, in, 1: vsync-derived frame strobe; asynchronous to `Clk`.
- `keycode`, in, 8: USB HID keycode of the current key.
- `centerx`, out, 10: sprite centre X.
- `centery`, out, 10: sprite centre Y.
- `airborne`, out, 1: high while in RISE or FALL.
- `facing`, out, 1: direction of the last horizontal move; 0 = right, 1 = left.

## Operation
- Frame tick:
  - `frame_clk` passes through a 2-FF synchronizer, then a rising-edge detector.
  - The detector produces `tick`, exactly one `Clk` cycle per frame.
  - Outputs change only on a `tick` cycle.
- Horizontal motion, evaluated on each tick:
  - Keycode 0x04 (A): `centerx` ← max(`centerx` − `STEP`, `HALF_W`); `facing` ← 1.
  - Keycode 0x07 (D): `centerx` ← min(`centerx` + `STEP`, 639 − `HALF_W`); `facing` ← 0.
  - Any other keycode: `centerx` and `facing` hold.
- Vertical state machine, with signed 6-bit velocity `vel`:
  - GROUND, keycode 0x1A (W) on tick: go to RISE; `vel` ← `JUMP_V0`; `centery` unchanged that tick.
  - RISE, on tick: `centery` ← `centery` − `vel`, clamped to ≥ `HALF_H`; `vel` ← `vel` − 1; if the new `vel` is 0, go to FALL.
  - FALL, on tick: `vel` ← min(`vel` + 1, `V_MAX`); `centery` ← `centery` + new `vel`.
  - FALL landing: if the sum is ≥ `Y_GROUND`, `centery` ← `Y_GROUND`, `vel` ← 0, go to GROUND.
  - Keycodes pressed during RISE or FALL are ignored for the vertical axis; horizontal motion continues.
- Arithmetic:
  - All position sums are computed in 11-bit signed form before clamping.
  - Outputs never leave [`HALF_W`, 639 − `HALF_W`] × [`HALF_H`, `Y_GROUND`].
- Reset state:
  - `centerx` = `X_START`; `centery` = `Y_GROUND`.
  - state = GROUND; `vel` = 0; `airborne` = 0; `facing` = 0.
  - Synchronizer flops are cleared.
  - Reset asserted mid-jump returns immediately to these values.

## Timing
- Latency from a `frame_clk` rising edge to the output update: 3 `Clk` cycles (2 synchronizer stages + 1 register).
- `keycode` is sampled only in the `tick` cycle; changes between ticks have no effect.
- `airborne` is registered and changes in the same cycle as the state.
- A full jump with default parameters lasts 24 ticks:
  - 12 RISE ticks, rising 78 px to peak `centery` 355.
  - 12 FALL ticks, landing at 433.
- `frame_clk` held high produces exactly one `tick`. Pulses shorter than 2 `Clk` periods are unsupported.

## Configuration
- `JOE_JUMP_EN` defined:
  - The jump state machine is compiled in, as described above.
- `JOE_JUMP_EN` undefined:
  - No state machine; `vel` is removed and `airborne` is tied to 0.
  - Keycode 0x1A (W): `centery` ← max(`centery` − `STEP`, `HALF_H`).
  - Keycode 0x16 (S): `centery` ← min(`centery` + `STEP`, `Y_GROUND`).

## Structure
- Package `joe_pkg`:
  - Keycode constants `KEY_A`, `KEY_D`, `KEY_W`, `KEY_S`.
  - `SCREEN_W` = 640, `SCREEN_H` = 480.
  - Default `HALF_W` and `HALF_H`.
  - Enum `jump_state_t` {GROUND, RISE, FALL}.
- One sub-module, `frame_tick_sync`:
  - Ports: `Clk`, `Reset`, `frame_clk` → `tick`.
  - Contents: 2-FF synchronizer plus edge detector.

## Test plan
- Reset asserted, then 5 ticks with keycode 0x00 → `centerx` = 320, `centery` = 433, `airborne` = 0, `facing` = 0 throughout.
- Keycode 0x07 held for 200 ticks → `centerx` climbs by 2 per tick and saturates at 597; `facing` = 0.
- Keycode 0x04 held for 200 ticks → `centerx` saturates at 42; `facing` = 1.
- Keycode 0x1A for one tick, then 0x00 → `airborne` rises; `centery` sequence 421, 410, …, 355; then back to 433 after 24 ticks total; `airborne` = 0.
- W held continuously → second jump starts on the first tick after landing, never during RISE or FALL.
- Reset pulsed asynchronously at tick 6 of a jump → outputs return to reset values within the same `Clk` edge; next W starts a fresh jump.
- Build without `JOE_JUMP_EN`, keycode 0x16 held → `centery` stays at 433; then 0x1A for 10 ticks → `centery` = 413.

Source files
------------

// File: rtl/joe_pkg.sv
// Shared constants and types for the Joe sprite motion block.
// Latency: n/a (package only).
// Backpressure: n/a.
package joe_pkg;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int DEF_HALF_W = 42;
    localparam int DEF_HALF_H = 46;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;

    // Saturate an 11-bit signed coordinate into [lo, hi].
    function automatic logic signed [10:0] clamp11(input logic signed [10:0] v,
                                                   input logic signed [10:0] lo,
                                                   input logic signed [10:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-derived frame strobe into Clk and emits a one-cycle tick per rising edge.
// Latency: tick is high in the cycle after the second synchronizer stage captures the edge.
// Backpressure: none; a frame_clk held high yields exactly one tick.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next-state for the two synchronizer stages and the edge-detector history.
    always_comb begin
        sync1_d = frame_clk;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and history flops, cleared by reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/joe_motion.sv
// Per-frame sprite centre generator: keyboard-driven walk plus optional jump (macro JOE_JUMP_EN).
// Latency: outputs update 3 Clk cycles after a frame_clk rising edge.
// Backpressure: none; keycode is sampled only in the tick cycle.
module joe_motion
    import joe_pkg::*;
#(
    parameter int X_START  = 320,
    parameter int Y_GROUND = SCREEN_H - 1 - DEF_HALF_H,
    parameter int HALF_W   = DEF_HALF_W,
    parameter int HALF_H   = DEF_HALF_H,
    parameter int STEP     = 2,
    parameter int JUMP_V0  = 12,
    parameter int V_MAX    = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] centerx,
    output logic [9:0] centery,
    output logic       airborne,
    output logic       facing
);

    localparam logic signed [10:0] X_MIN  = 11'(HALF_W);
    localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - 1 - HALF_W);
    localparam logic signed [10:0] Y_MIN  = 11'(HALF_H);
    localparam logic signed [10:0] Y_MAX  = 11'(Y_GROUND);
    localparam logic signed [10:0] STEP11 = 11'(STEP);

    logic tick;

    frame_tick_sync u_sync (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .tick     (tick)
    );

    logic [9:0] centerx_q, centerx_d;
    logic [9:0] centery_q, centery_d;
    logic       facing_q,  facing_d;
    logic signed [10:0] x_s, y_s, nx;

    assign x_s = signed'({1'b0, centerx_q});
    assign y_s = signed'({1'b0, centery_q});

    // Horizontal walk: A/D move by STEP and set facing, clamped to the screen.
    always_comb begin
        centerx_d = centerx_q;
        facing_d  = facing_q;
        nx        = x_s;
        if (tick) begin
            if (keycode == KEY_A) begin
                nx        = clamp11(x_s - STEP11, X_MIN, X_MAX);
                centerx_d = nx[9:0];
                facing_d  = 1'b1;
            end else if (keycode == KEY_D) begin
                nx        = clamp11(x_s + STEP11, X_MIN, X_MAX);
                centerx_d = nx[9:0];
                facing_d  = 1'b0;
            end
        end
    end

`ifdef JOE_JUMP_EN
    jump_state_t        state_q, state_d;
    logic signed [5:0]  vel_q, vel_d, vel_n;
    logic               airborne_q, airborne_d;
    logic signed [10:0] ny;

    // Jump FSM: launch on W from the ground, decelerate while rising, accelerate while falling.
    always_comb begin
        state_d   = state_q;
        vel_d     = vel_q;
        vel_n     = vel_q;
        centery_d = centery_q;
        ny        = y_s;
        if (tick) begin
            case (state_q)
                GROUND: begin
                    if (keycode == KEY_W) begin
                        state_d = RISE;
                        vel_d   = 6'(JUMP_V0);
                    end
                end
                RISE: begin
                    ny        = clamp11(y_s - 11'(vel_q), Y_MIN, Y_MAX);
                    centery_d = ny[9:0];
                    vel_n     = vel_q - 6'sd1;
                    vel_d     = vel_n;
                    if (vel_n == 6'sd0)
                        state_d = FALL;
                end
                FALL: begin
                    vel_n = (vel_q >= 6'(V_MAX)) ? 6'(V_MAX) : vel_q + 6'sd1;
                    ny    = y_s + 11'(vel_n);
                    if (ny >= Y_MAX) begin
                        centery_d = Y_MAX[9:0];
                        vel_d     = 6'sd0;
                        state_d   = GROUND;
                    end else begin
                        centery_d = ny[9:0];
                        vel_d     = vel_n;
                    end
                end
                default: begin
                    state_d = GROUND;
                    vel_d   = 6'sd0;
                end
            endcase
        end
        airborne_d = (state_d != GROUND);
    end

    // Jump state, velocity and the registered airborne flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= GROUND;
            vel_q      <= 6'sd0;
            airborne_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vel_q      <= vel_d;
            airborne_q <= airborne_d;
        end
    end

    assign airborne = airborne_q;
`else
    logic [11:0] unused_jump;
    assign unused_jump = {6'(JUMP_V0), 6'(V_MAX)};

    logic signed [10:0] ny;

    // Free vertical walk: W moves up, S moves down, clamped to the play area.
    always_comb begin
        centery_d = centery_q;
        ny        = y_s;
        if (tick) begin
            if (keycode == KEY_W) begin
                ny        = clamp11(y_s - STEP11, Y_MIN, Y_MAX);
                centery_d = ny[9:0];
            end else if (keycode == KEY_S) begin
                ny        = clamp11(y_s + STEP11, Y_MIN, Y_MAX);
                centery_d = ny[9:0];
            end
        end
    end

    assign airborne = 1'b0;
`endif

    // Position and facing registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            centerx_q <= 10'(X_START);
            centery_q <= 10'(Y_GROUND);
            facing_q  <= 1'b0;
        end else begin
            centerx_q <= centerx_d;
            centery_q <= centery_d;
            facing_q  <= facing_d;
        end
    end

    assign centerx = centerx_q;
    assign centery = centery_q;
    assign facing  = facing_q;

endmodule
